// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: stream source / memory side, slave: the loader itself.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  byte_valid_i;
  logic [7:0]            byte_data_i;
  logic                  byte_ready_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;

  modport master (
    output byte_valid_i,
    output byte_data_i,
    input  byte_ready_o,
    input  wr_en_o,
    input  wr_addr_o,
    input  wr_data_o
  );

  modport slave (
    input  byte_valid_i,
    input  byte_data_i,
    output byte_ready_o,
    output wr_en_o,
    output wr_addr_o,
    output wr_data_o
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: header word N, then N little-endian program words written to the
// instruction memory by word index. Optional trailing checksum: IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PROGRAM_LENGTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  imem_boot_loader_if.slave     bus,
  output logic                  core_stall_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] word_count_o
);

  localparam logic [DATA_WIDTH-1:0] MAX_WORDS = DATA_WIDTH'(PROGRAM_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_WORD  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    ST_CSUM  = 3'd3
`endif
  } state_t;

  state_t                state_r;
  logic [1:0]            byte_cnt_r;
  logic [DATA_WIDTH-9:0] shift_r;
  logic [ADDR_WIDTH-1:0] n_words_r;
  logic [ADDR_WIDTH-1:0] word_count_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic                  ready_r;
  logic                  busy_r;
  logic                  stall_r;
  logic                  done_r;
  logic                  error_r;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_r;

  function automatic logic [DATA_WIDTH-1:0] csum_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] word
  );
    return acc + word;
  endfunction
`endif

  logic                  byte_fire_s;
  logic                  word_fire_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  hdr_bad_s;
  logic                  last_word_s;

  // Handshake decode and the word completed by the byte on the bus.
  always_comb begin
    byte_fire_s = bus.byte_valid_i & ready_r;
    word_fire_s = byte_fire_s & (byte_cnt_r == 2'd3);
    word_s      = {bus.byte_data_i, shift_r};
    hdr_bad_s   = (word_s == {DATA_WIDTH{1'b0}}) || (word_s > MAX_WORDS);
    last_word_s = ((word_count_r + ONE_WORD) == n_words_r);
  end

  // Load sequencer: state, byte assembly, write port and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      byte_cnt_r   <= 2'd0;
      shift_r      <= {(DATA_WIDTH-8){1'b0}};
      n_words_r    <= {ADDR_WIDTH{1'b0}};
      word_count_r <= {ADDR_WIDTH{1'b0}};
      wr_en_r      <= 1'b0;
      wr_addr_r    <= {ADDR_WIDTH{1'b0}};
      wr_data_r    <= {DATA_WIDTH{1'b0}};
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      stall_r      <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum_r       <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      wr_en_r <= 1'b0;
      if (byte_fire_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        shift_r    <= {bus.byte_data_i, shift_r[DATA_WIDTH-9:8]};
      end

      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // Without a checksum, done follows the final write strobe by one cycle.
          if (state_r == ST_DONE) begin
            done_r  <= 1'b1;
            stall_r <= 1'b0;
          end
          if (start_i) begin
            state_r      <= ST_HDR;
            ready_r      <= 1'b1;
            busy_r       <= 1'b1;
            stall_r      <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            word_count_r <= {ADDR_WIDTH{1'b0}};
            byte_cnt_r   <= 2'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_r       <= {DATA_WIDTH{1'b0}};
`endif
          end
        end

        ST_HDR: begin
          if (word_fire_s) begin
            if (hdr_bad_s) begin
              state_r <= ST_ERROR;
              ready_r <= 1'b0;
              busy_r  <= 1'b0;
              error_r <= 1'b1;
            end else begin
              state_r   <= ST_DATA;
              n_words_r <= ADDR_WIDTH'(word_s);
            end
          end
        end

        ST_DATA: begin
          if (word_fire_s) begin
            wr_en_r      <= 1'b1;
            wr_addr_r    <= word_count_r;
            wr_data_r    <= word_s;
            word_count_r <= word_count_r + ONE_WORD;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_r       <= csum_add(csum_r, word_s);
            if (last_word_s) begin
              state_r <= ST_CSUM;
            end
`else
            if (last_word_s) begin
              state_r <= ST_DONE;
              ready_r <= 1'b0;
              busy_r  <= 1'b0;
            end
`endif
          end
        end

`ifdef IMEM_BOOT_CHECKSUM_EN
        ST_CSUM: begin
          if (word_fire_s) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            if (word_s == csum_r) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              stall_r <= 1'b0;
            end else begin
              state_r <= ST_ERROR;
              error_r <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_r <= ST_ERROR;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          stall_r <= 1'b1;
          error_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready_o = ready_r;
  assign bus.wr_en_o      = wr_en_r;
  assign bus.wr_addr_o    = wr_addr_r;
  assign bus.wr_data_o    = wr_data_r;
  assign core_stall_o     = stall_r;
  assign busy_o           = busy_r;
  assign done_o           = done_r;
  assign error_o          = error_r;
  assign word_count_o     = word_count_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a reference model builds each byte stream
// and queues the expected writes; a monitor pops and compares every write strobe.
module tb_imem_boot_loader;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PL = 10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          core_stall;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] word_count;

  imem_boot_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROGRAM_LENGTH(PL)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .bus          (bus_if),
    .core_stall_o (core_stall),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .word_count_o (word_count)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  last_wr_cyc = -100;
  int  prev_wr_cyc = -100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_if.wr_en_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%h, required no write",
                   bus_if.wr_addr_o, bus_if.wr_data_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus_if.wr_addr_o), 64'(e.addr));
          check("wr_data", 64'(bus_if.wr_data_o), 64'(e.data));
        end
        if (cyc - last_wr_cyc < 4) begin
          total++;
          bad++;
          $display("FAIL wr_rate: got writes %0d cycles apart, required at least 4",
                   cyc - last_wr_cyc);
        end
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers one byte (after optional random idle cycles); acc reports the handshake.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit acc);
    int waited;
    while ($urandom_range(99) < gap_pct) begin
      bus_if.byte_valid_i = 1'b0;
      @(posedge clk); #1;
    end
    bus_if.byte_valid_i = 1'b1;
    bus_if.byte_data_i  = b;
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < 40) begin
      @(negedge clk);
      acc = bus_if.byte_ready_o;
      @(posedge clk); #1;
      waited++;
    end
    bus_if.byte_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(bus_if.byte_ready_o), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    check("start_err_clr", 64'(error), 64'd0);
    check("start_wc_clr", 64'(word_count), 64'd0);
    check("start_stall", 64'(core_stall), 64'd1);
    @(posedge clk); #1;
  endtask

  // Reference model: header, words and optional sum, with expected writes and outcome.
  task automatic run_load(input logic [31:0] hdr, input logic [31:0] words[$],
                          input bit corrupt_csum, input int gap_pct, input bit poke_start);
    logic [7:0]  s[$];
    logic [31:0] sum;
    bit          good;
    bit          exp_done;
    bit          done_fast;
    bit          acc;
    good      = (hdr != 32'd0) && (hdr <= 32'(PL));
    sum       = 32'd0;
    exp_done  = 1'b0;
    done_fast = 1'b0;
    for (int i = 0; i < 4; i++) s.push_back(hdr[8*i +: 8]);
    if (good) begin
      for (int k = 0; k < words.size(); k++) begin
        for (int i = 0; i < 4; i++) s.push_back(words[k][8*i +: 8]);
        sum = sum + words[k];
        exp_q.push_back('{32'(k), words[k]});
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      if (corrupt_csum) sum = sum + 32'd1;
      for (int i = 0; i < 4; i++) s.push_back(sum[8*i +: 8]);
      exp_done  = !corrupt_csum;
      done_fast = 1'b1;
`else
      exp_done  = 1'b1;
      done_fast = 1'b0;
`endif
    end
    pulse_start();
    for (int i = 0; i < s.size(); i++) begin
      if (poke_start && i == 6) start_i = 1'b1;
      send_byte(s[i], gap_pct, acc);
      start_i = 1'b0;
      if (!acc) begin
        check("byte_accept_timeout", 64'd0, 64'd1);
        return;
      end
    end
    @(negedge clk);
    check("end_ready_drop", 64'(bus_if.byte_ready_o), 64'd0);
    check("end_done_c1", 64'(done), 64'(exp_done && done_fast));
    check("end_error_c1", 64'(error), 64'(!exp_done));
    @(negedge clk);
    check("final_done", 64'(done), 64'(exp_done));
    check("final_error", 64'(error), 64'(!exp_done));
    check("final_stall", 64'(core_stall), 64'(!exp_done));
    check("final_busy", 64'(busy), 64'd0);
    check("final_wc", 64'(word_count), good ? 64'(words.size()) : 64'd0);
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] none[$];
    logic [31:0] rw[$];
    logic [7:0]  rs[$];
    bit          acc;
    int          n;

    rst = 1'b1;
    start_i = 1'b0;
    bus_if.byte_valid_i = 1'b0;
    bus_if.byte_data_i  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(core_stall), 64'd1);
    check("rst_ready", 64'(bus_if.byte_ready_o), 64'd0);
    check("rst_wr_en", 64'(bus_if.wr_en_o), 64'd0);
    check("rst_wr_addr", 64'(bus_if.wr_addr_o), 64'd0);
    check("rst_wr_data", 64'(bus_if.wr_data_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wc", 64'(word_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    prog = '{32'h00500093, 32'h00A00113};
    run_load(32'd2, prog, 1'b0, 0, 1'b0);
    check("wr_spacing_gapless", 64'(last_wr_cyc - prev_wr_cyc), 64'd4);

    run_load(32'd11, none, 1'b0, 0, 1'b0);
    send_byte(8'h55, 0, acc);
    check("no_accept_after_error", 64'(acc), 64'd0);
    run_load(32'd0, none, 1'b0, 0, 1'b0);

    run_load(32'd2, prog, 1'b0, 40, 1'b1);
`ifdef IMEM_BOOT_CHECKSUM_EN
    run_load(32'd2, prog, 1'b1, 0, 1'b0);
`endif

    // Reset after five data bytes: only word 0 is written, nothing afterwards.
    rs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
    exp_q.push_back('{32'd0, 32'h00500093});
    pulse_start();
    foreach (rs[i]) send_byte(rs[i], 0, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stall", 64'(core_stall), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(bus_if.byte_ready_o), 64'd0);
    check("midrst_wc", 64'(word_count), 64'd0);
    check("midrst_wr_en", 64'(bus_if.wr_en_o), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_writes", 64'(exp_q.size()), 64'd0);
    run_load(32'd2, prog, 1'b0, 0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, PL + 2);
      rw.delete();
      if (n >= 1 && n <= PL) begin
        for (int k = 0; k < n; k++) rw.push_back($urandom);
      end
      run_load(32'(n), rw, ($urandom_range(0, 3) == 0), $urandom_range(0, 50),
               ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Sequential loader that fills the instruction memory from a byte stream before the core runs. It receives a little-endian word-count header followed by program words and emits one word-indexed write per assembled word. It holds the core stalled until a valid program is resident, making it the sole writer and sequencer of the instruction ROM contents at boot.

## Interface
- ADDR_WIDTH, 32, width of instruction-memory word index (`wr_addr_o`)
- DATA_WIDTH, 32, instruction width; only 32 is supported
- PROGRAM_LENGTH, 10, instruction-memory depth in words; maximum accepted program length
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  begin a load; honoured only in IDLE, DONE, ERROR
- byte_valid_i  in  1  byte stream valid
- byte_data_i  in  8  byte stream data
- byte_ready_o  out  1  loader accepts a byte this cycle
- wr_en_o  out  1  one-cycle instruction-memory write strobe
- wr_addr_o  out  ADDR_WIDTH  word index (0-based, not byte address)
- wr_data_o  out  DATA_WIDTH  assembled instruction word
- core_stall_o  out  1  holds core fetch/PC while no valid program is loaded
- busy_o  out  1  in HDR, DATA or CSUM
- done_o  out  1  valid program loaded (sticky)
- error_o  out  1  load failed (sticky)
- word_count_o  out  ADDR_WIDTH  words written in current/last load

## Operation
- States: IDLE, HDR, DATA, CSUM (only with checksum feature), DONE, ERROR.
- Byte handshake: transfer when `byte_valid_i & byte_ready_o` at rising edge. `byte_ready_o` = 1 in HDR/DATA/CSUM, else 0.
- Bytes assembled little-endian: first byte -> bits [7:0], fourth -> [31:24]; 2-bit byte counter wraps 3->0.
- IDLE/DONE/ERROR + `start_i` -> HDR; clears `done_o`, `error_o`, `word_count_o`, byte counter, checksum accumulator.
- HDR: after 4 bytes, N = header word. N == 0 or N > PROGRAM_LENGTH -> ERROR; else latch N, -> DATA.
- DATA: each 4th byte registers a write: `wr_addr_o` = `word_count_o`, `wr_data_o` = word, `word_count_o` increments. After word N: -> DONE (or CSUM if enabled).
- DONE: `done_o` = 1, `core_stall_o` = 0.
- ERROR: `error_o` = 1, `core_stall_o` = 1.
- `start_i` in HDR/DATA/CSUM ignored; load continues.
- No per-byte timeout; an idle stream holds state indefinitely.

## Timing
- Reset values: state IDLE, `byte_ready_o` 0, `wr_en_o` 0, `wr_addr_o` 0, `wr_data_o` 0, `core_stall_o` 1, `busy_o` 0, `done_o` 0, `error_o` 0, `word_count_o` 0.
- All outputs registered.
- `wr_en_o` high exactly one cycle, the cycle after the 4th byte of a word is accepted; `wr_addr_o`/`wr_data_o` valid in that cycle and held afterwards.
- Back-to-back bytes every cycle sustained; max one write per 4 cycles.
- `done_o` rises and `core_stall_o` falls the cycle after the final `wr_en_o` pulse (no checksum) or the cycle after the 4th checksum byte is accepted (match).
- `error_o` rises the cycle after the 4th header byte (bad N) or 4th checksum byte (mismatch).
- `byte_ready_o` drops in the same cycle the state leaves HDR/DATA/CSUM (no byte accepted after last needed byte).
- `rst` mid-load: returns to IDLE next edge, pending write dropped, `core_stall_o` 1; partial memory contents not scrubbed.

## Configuration
- `IMEM_BOOT_CHECKSUM_EN` defined: after N words, 4 more little-endian bytes = sum of all N words mod 2^32; match -> DONE, mismatch -> ERROR. CSUM state exists.
- Undefined: no CSUM state, no accumulator; DATA -> DONE directly; stream ends after last data byte.

## Test plan
- Reset: assert `rst` 2 cycles -> `core_stall_o` 1, all other outputs 0, `byte_ready_o` 0.
- Header 02 00 00 00, words 0x00500093, 0x00A00113 (bytes 93 00 50 00 13 01 A0 00), no gaps -> `wr_en_o` pulses at addr 0 then addr 1 with those words, 4 cycles apart; `done_o` 1, `core_stall_o` 0, `word_count_o` 2.
- Header 0B 00 00 00 (N=11 > 10) -> `error_o` 1 next cycle, no `wr_en_o`, `byte_ready_o` 0; header 00 00 00 00 -> same.
- Same program with random `byte_valid_i` gaps -> identical writes and final state.
- `rst` after 5 data bytes -> IDLE, no further `wr_en_o`; new `start_i` + full stream loads correctly from addr 0.
- With `IMEM_BOOT_CHECKSUM_EN`: above program + checksum 0x00F001A6 (A6 01 F0 00) -> `done_o` 1; checksum 0x00F001A7 -> `error_o` 1, `core_stall_o` 1.
